// File: rtl/bp_common_pkg.sv
// Shared types and defaults for the address router: device count, default
// base/mask decode table (zero-extended to 64 bits) and the order-FIFO tag.
package bp_common_pkg;

  localparam int num_dev_gp      = 5;
  localparam int dev_id_width_gp = $clog2(num_dev_gp);
  localparam int table_width_gp  = 64;

  typedef logic [num_dev_gp-1:0][table_width_gp-1:0] addr_table_t;

  localparam addr_table_t dev_base_default_gp = {
    64'h0C00_0000, 64'h0300_0000, 64'h0200_0000, 64'h0100_0000, 64'h8000_0000
  };
  localparam addr_table_t dev_mask_default_gp = {
    64'hFF00_0000, 64'hFF00_0000, 64'hFF00_0000, 64'hFF00_0000, 64'h8000_0000
  };

  typedef struct packed {
    logic                       err;
    logic [dev_id_width_gp-1:0] dev_id;
  } tag_s;

endpackage

// File: rtl/bp_addr_router_tag_fifo.sv
// Order FIFO holding one tag per in-flight command; depth must be a power of
// two so the pointers wrap naturally.
module bp_addr_router_tag_fifo
  import bp_common_pkg::*;
#(
  parameter int depth_p = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  tag_s                     data_i,
  input  logic                     pop_i,
  output tag_s                     data_o,
  output logic                     empty_o,
  output logic [$clog2(depth_p):0] count_o
);

  localparam int ptr_width_lp = $clog2(depth_p);

  tag_s                    mem_r [depth_p];
  logic [ptr_width_lp-1:0] wptr_r, rptr_r;
  logic [ptr_width_lp:0]   count_r;

  // NOTE: storage is not reset; an entry is only read once count_r says it was written.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_r[wptr_r] <= data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_i) wptr_r <= wptr_r + 1'b1;
      if (pop_i)  rptr_r <= rptr_r + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign data_o  = mem_r[rptr_r];
  assign empty_o = (count_r == '0);
  assign count_o = count_r;

endmodule

// File: rtl/bp_addr_router.sv
// Address router: decodes commands to one of num_dev_p devices and returns
// responses in command order. Define BP_ADDR_ROUTER_DECODE_ERR_EN to flag unmapped commands.
module bp_addr_router
  import bp_common_pkg::*;
#(
  parameter int          paddr_width_p = 56,
  parameter int          data_width_p  = 64,
  parameter int          num_dev_p     = num_dev_gp,
  parameter int          outstanding_p = 4,
  parameter addr_table_t dev_base_p    = dev_base_default_gp,
  parameter addr_table_t dev_mask_p    = dev_mask_default_gp
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              cmd_v_i,
  output logic                              cmd_ready_o,
  input  logic [paddr_width_p-1:0]          cmd_addr_i,
  input  logic [data_width_p-1:0]           cmd_data_i,
  output logic [num_dev_p-1:0]              dev_cmd_v_o,
  input  logic [num_dev_p-1:0]              dev_cmd_ready_i,
  output logic [paddr_width_p-1:0]          dev_cmd_addr_o,
  output logic [data_width_p-1:0]           dev_cmd_data_o,
  input  logic [num_dev_p-1:0]              dev_resp_v_i,
  output logic [num_dev_p-1:0]              dev_resp_yumi_o,
  input  logic [num_dev_p*data_width_p-1:0] dev_resp_data_i,
  output logic                              resp_v_o,
  input  logic                              resp_yumi_i,
  output logic [data_width_p-1:0]           resp_data_o,
  output logic                              resp_err_o
);

  localparam int cnt_width_lp = $clog2(outstanding_p) + 1;

  logic                       hit;
  logic [dev_id_width_gp-1:0] hit_id;
  logic                       fwd;
  tag_s                       cmd_tag, head;
  logic                       fifo_empty;
  logic [cnt_width_lp-1:0]    fifo_count;
  logic                       ready_en_r, out_v_r, out_fire, cmd_fire, resp_pop;
  logic [dev_id_width_gp-1:0] out_dev_r;
  logic [paddr_width_p-1:0]   out_addr_r;
  logic [data_width_p-1:0]    out_data_r;

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    hit    = 1'b0;
    hit_id = '0;
    for (int i = num_dev_p - 1; i >= 0; i--) begin
      if ((cmd_addr_i & dev_mask_p[i][paddr_width_p-1:0]) == dev_base_p[i][paddr_width_p-1:0]) begin
        hit    = 1'b1;
        hit_id = dev_id_width_gp'(i);
      end
    end
  end

`ifdef BP_ADDR_ROUTER_DECODE_ERR_EN
  assign fwd     = hit;
  assign cmd_tag = '{err: ~hit, dev_id: hit_id};
`else
  logic unused_miss;
  assign unused_miss = ~hit;
  assign fwd         = 1'b1;
  assign cmd_tag     = '{err: 1'b0, dev_id: hit_id};
`endif

  assign out_fire    = out_v_r & dev_cmd_ready_i[out_dev_r];
  // ready_en_r holds acceptance off until the first edge after reset releases.
  assign cmd_ready_o = ready_en_r & (~out_v_r | out_fire)
                     & (fifo_count < cnt_width_lp'(outstanding_p));
  assign cmd_fire    = cmd_v_i & cmd_ready_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ready_en_r <= 1'b0;
      out_v_r    <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
      if (cmd_fire & fwd) out_v_r <= 1'b1;
      else if (out_fire)  out_v_r <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (cmd_fire & fwd) begin
      out_dev_r  <= hit_id;
      out_addr_r <= cmd_addr_i;
      out_data_r <= cmd_data_i;
    end
  end

  always_comb begin
    dev_cmd_v_o            = '0;
    dev_cmd_v_o[out_dev_r] = out_v_r;
  end
  assign dev_cmd_addr_o = out_addr_r;
  assign dev_cmd_data_o = out_data_r;

  bp_addr_router_tag_fifo #(.depth_p(outstanding_p)) tag_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (cmd_fire),
    .data_i  (cmd_tag),
    .pop_i   (resp_pop),
    .data_o  (head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    resp_v_o        = 1'b0;
    resp_data_o     = '0;
    resp_err_o      = 1'b0;
    dev_resp_yumi_o = '0;
    if (!fifo_empty) begin
`ifdef BP_ADDR_ROUTER_DECODE_ERR_EN
      if (head.err) begin
        resp_v_o   = 1'b1;
        resp_err_o = 1'b1;
      end else begin
`else
      begin
`endif
        resp_v_o                     = dev_resp_v_i[head.dev_id];
        resp_data_o                  = dev_resp_data_i[head.dev_id*data_width_p +: data_width_p];
        dev_resp_yumi_o[head.dev_id] = resp_yumi_i & resp_v_o;
      end
    end
  end

`ifndef BP_ADDR_ROUTER_DECODE_ERR_EN
  logic unused_head_err;
  assign unused_head_err = head.err;
`endif

  assign resp_pop = resp_v_o & resp_yumi_i;

endmodule

// File: tb/tb_bp_addr_router.sv
// Self-checking bench for bp_addr_router: directed scenarios plus random
// traffic compared against a queue-based transaction model.
module tb_bp_addr_router;

  localparam int aw = 56;
  localparam int dw = 64;
  localparam int nd = 5;
  localparam int os = 4;

`ifdef BP_ADDR_ROUTER_DECODE_ERR_EN
  localparam bit err_en = 1'b1;
`else
  localparam bit err_en = 1'b0;
`endif

  logic             clk, reset_i;
  logic             cmd_v_i, cmd_ready_o;
  logic [aw-1:0]    cmd_addr_i;
  logic [dw-1:0]    cmd_data_i;
  logic [nd-1:0]    dev_cmd_v_o, dev_cmd_ready_i;
  logic [aw-1:0]    dev_cmd_addr_o;
  logic [dw-1:0]    dev_cmd_data_o;
  logic [nd-1:0]    dev_resp_v_i, dev_resp_yumi_o;
  logic [nd*dw-1:0] dev_resp_data_i;
  logic             resp_v_o, resp_yumi_i, resp_err_o;
  logic [dw-1:0]    resp_data_o;

  bp_addr_router dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .cmd_v_i         (cmd_v_i),
    .cmd_ready_o     (cmd_ready_o),
    .cmd_addr_i      (cmd_addr_i),
    .cmd_data_i      (cmd_data_i),
    .dev_cmd_v_o     (dev_cmd_v_o),
    .dev_cmd_ready_i (dev_cmd_ready_i),
    .dev_cmd_addr_o  (dev_cmd_addr_o),
    .dev_cmd_data_o  (dev_cmd_data_o),
    .dev_resp_v_i    (dev_resp_v_i),
    .dev_resp_yumi_o (dev_resp_yumi_o),
    .dev_resp_data_i (dev_resp_data_i),
    .resp_v_o        (resp_v_o),
    .resp_yumi_i     (resp_yumi_i),
    .resp_data_o     (resp_data_o),
    .resp_err_o      (resp_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Transaction model: queue of owed responses (device index, -1 = decode error),
  // the single command waiting at the device side, and whether accepting is allowed yet.
  int            order_q[$];
  bit            pend_v;
  int            pend_dev;
  logic [aw-1:0] pend_addr;
  logic [dw-1:0] pend_data;
  bit            started;

  logic [aw-1:0] base_t[nd] = '{56'h8000_0000, 56'h0100_0000, 56'h0200_0000, 56'h0300_0000, 56'h0C00_0000};
  logic [aw-1:0] mask_t[nd] = '{56'h8000_0000, 56'hFF00_0000, 56'hFF00_0000, 56'hFF00_0000, 56'hFF00_0000};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int decode(input logic [aw-1:0] a);
    for (int i = 0; i < nd; i++)
      if ((a & mask_t[i]) == base_t[i]) return i;
    return err_en ? -1 : 0;
  endfunction

  task automatic cycle(input bit cv, input logic [aw-1:0] a, input logic [dw-1:0] d,
                       input logic [nd-1:0] dcr, input logic [nd-1:0] drv, input bit ry);
    bit            exp_ready, ev, eerr, acc, fire, pop;
    logic [nd-1:0] exp_dv, eyumi;
    logic [dw-1:0] edata;
    int            h, tgt;
    @(negedge clk);
    cmd_v_i         = cv;
    cmd_addr_i      = a;
    cmd_data_i      = d;
    dev_cmd_ready_i = dcr;
    dev_resp_v_i    = drv;
    resp_yumi_i     = ry;
    for (int k = 0; k < nd; k++) dev_resp_data_i[k*dw +: dw] = {$urandom, $urandom};
    #1;
    exp_ready = started && (!pend_v || dcr[pend_dev]) && (order_q.size() < os);
    check("cmd_ready", cmd_ready_o, exp_ready);
    exp_dv = pend_v ? (nd'(1) << pend_dev) : '0;
    check("dev_cmd_v", dev_cmd_v_o, exp_dv);
    if (pend_v) begin
      check("dev_cmd_addr", dev_cmd_addr_o, pend_addr);
      check("dev_cmd_data", dev_cmd_data_o, pend_data);
    end
    ev = 0; eerr = 0; edata = '0; eyumi = '0;
    if (order_q.size() > 0) begin
      h = order_q[0];
      if (h < 0) begin
        ev = 1; eerr = 1;
      end else begin
        ev    = drv[h];
        edata = dev_resp_data_i[h*dw +: dw];
        if (ev && ry) eyumi = nd'(1) << h;
      end
    end
    check("resp_v", resp_v_o, ev);
    check("resp_err", resp_err_o, eerr);
    if (ev) check("resp_data", resp_data_o, edata);
    check("dev_resp_yumi", dev_resp_yumi_o, eyumi);
    acc  = cv && exp_ready;
    fire = pend_v && dcr[pend_dev];
    pop  = ev && ry;
    tgt  = decode(a);
    @(posedge clk);
    started = 1;
    if (fire) pend_v = 0;
    if (acc && tgt >= 0) begin
      pend_v = 1; pend_dev = tgt; pend_addr = a; pend_data = d;
    end
    if (pop) void'(order_q.pop_front());
    if (acc) order_q.push_back(tgt);
  endtask

  task automatic idle(input logic [nd-1:0] dcr, input logic [nd-1:0] drv, input bit ry);
    cycle(1'b0, '0, '0, dcr, drv, ry);
  endtask

  task automatic drain();
    int n = 0;
    while ((order_q.size() > 0 || pend_v) && n < 50) begin
      idle('1, '1, 1'b1);
      n++;
    end
    if (n == 50) check("drain_timeout", order_q.size(), 0);
  endtask

  // Asserts reset asynchronously between edges, holds it across a rising edge,
  // releases it away from the edge, then confirms ready stays low until the next edge.
  task automatic reset_seq();
    @(negedge clk);
    cmd_v_i = 1; cmd_addr_i = 56'h0100_0000; dev_cmd_ready_i = '1;
    dev_resp_v_i = '1; resp_yumi_i = 1;
    #2 reset_i = 1;
    #1;
    check("rst_cmd_ready", cmd_ready_o, 0);
    check("rst_dev_cmd_v", dev_cmd_v_o, 0);
    check("rst_resp_v", resp_v_o, 0);
    check("rst_resp_err", resp_err_o, 0);
    check("rst_dev_resp_yumi", dev_resp_yumi_o, 0);
    @(negedge clk);
    reset_i = 0;
    cmd_v_i = 0;
    order_q.delete();
    pend_v  = 0;
    started = 0;
    #1;
    check("post_rst_cmd_ready", cmd_ready_o, 0);
    check("post_rst_resp_v", resp_v_o, 0);
    @(posedge clk);
    started = 1;
  endtask

  function automatic logic [aw-1:0] rand_addr();
    int sel = $urandom_range(0, 6);
    case (sel)
      0:       return 56'h8000_0000 | aw'($urandom_range(0, 32'h7FFF_FFFF));
      1, 2, 3, 4: return base_t[sel] | aw'($urandom_range(0, 32'h00FF_FFFF));
      5:       return 56'h0400_0000 | aw'($urandom_range(0, 32'h00FF_FFFF));
      default: return aw'({$urandom, $urandom});
    endcase
  endfunction

  initial begin
    reset_i = 0; cmd_v_i = 0; cmd_addr_i = '0; cmd_data_i = '0;
    dev_cmd_ready_i = '0; dev_resp_v_i = '0; resp_yumi_i = 0; dev_resp_data_i = '0;
    pend_v = 0; pend_dev = 0; started = 0;
    reset_seq();

    // Single command to device 0 and its response.
    cycle(1, 56'h8000_1000, 64'hDEAD, '0, '0, 0);
    idle(5'b00001, '0, 0);
    idle('0, 5'b00001, 1);
    drain();

    // Out-of-order device responses are held until the head device answers.
    cycle(1, 56'h0200_4000, 64'h11, '1, '0, 0);
    cycle(1, 56'h0C00_0000, 64'h22, '1, '0, 0);
    idle('1, 5'b10000, 1);
    idle('1, 5'b10000, 1);
    idle('1, 5'b00100, 1);
    idle('1, 5'b10000, 1);
    drain();

    // Fill all outstanding slots, then free one.
    for (int i = 0; i < os; i++) cycle(1, 56'h0100_0000 + aw'(i), 64'(i), '1, '0, 0);
    cycle(1, 56'h0100_0010, 64'h99, '1, '0, 0);
    idle('1, 5'b00010, 1);
    cycle(1, 56'h0100_0020, 64'h98, '1, '0, 0);
    drain();

    // Unmapped address.
    cycle(1, 56'h0400_0000, 64'h5A, '0, '0, 0);
    idle('0, '0, 0);
    idle('1, '0, 1);
    drain();

    // Device 0 back-pressure for three cycles.
    cycle(1, 56'h8000_0040, 64'hCAFE, '0, '0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 56'h0300_0000, 64'h77, '0, '0, 0);
    idle(5'b00001, '0, 0);
    drain();

    // Reset with two commands in flight; late responses must be ignored.
    cycle(1, 56'h0200_0000, 64'h1, '1, '0, 0);
    cycle(1, 56'h0300_0000, 64'h2, '1, '0, 0);
    reset_seq();
    for (int i = 0; i < 4; i++) idle('1, '1, 1);

    for (int i = 0; i < 800; i++) begin
      if (i == 400) reset_seq();
      cycle($urandom_range(0, 3) != 0, rand_addr(), {$urandom, $urandom},
            nd'($urandom), nd'($urandom), $urandom_range(0, 1) == 1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bp_addr_router.md
BP_ADDR_ROUTER -- requirements
Module: bp_addr_router

Interface
REQ-001 Parameter paddr_width_p, default 56: physical address width.
REQ-002 Parameter data_width_p, default 64: command/response payload width.
REQ-003 Parameter num_dev_p, default 5: number of device channels.
REQ-004 Parameter outstanding_p, default 4: maximum in-flight commands; power of two, at least 2.
REQ-005 Parameter dev_base_p, default {0x0C00_0000, 0x0300_0000, 0x0200_0000, 0x0100_0000, 0x8000_0000} (index 4..0): per-device match base.
REQ-006 Parameter dev_mask_p, default {0xFF00_0000 x4, 0x8000_0000} (index 4..0), zero-extended to paddr_width_p: per-device match mask.
REQ-007 clk_i  in  1  sole clock, rising edge.
REQ-008 reset_i  in  1  reset, asynchronous assert, active-high.
REQ-009 cmd_v_i / cmd_ready_o  in/out  1/1  upstream command valid / ready.
REQ-010 cmd_addr_i / cmd_data_i  in  paddr_width_p / data_width_p  command address / payload.
REQ-011 dev_cmd_v_o / dev_cmd_ready_i  out/in  num_dev_p / num_dev_p  per-device command valid / ready.
REQ-012 dev_cmd_addr_o / dev_cmd_data_o  out  paddr_width_p / data_width_p  command bus shared by all devices.
REQ-013 dev_resp_v_i / dev_resp_yumi_o  in/out  num_dev_p / num_dev_p  per-device response valid / consume.
REQ-014 dev_resp_data_i  in  num_dev_p*data_width_p  per-device response payloads.
REQ-015 resp_v_o / resp_yumi_i  out/in  1/1  upstream response valid / consume.
REQ-016 resp_data_o / resp_err_o  out  data_width_p / 1  response payload / decode-error flag.

Function
REQ-017 Decode: device i matches when (cmd_addr_i & mask_i) == base_i; the lowest matching index wins; no match means unmapped.
REQ-018 Transfer occurs when cmd_v_i & cmd_ready_o; the decoded target goes into a one-entry output register and its tag is pushed into the order FIFO in the same cycle.
REQ-019 cmd_ready_o = (output register empty, or its transfer completes this cycle) & (order FIFO count < outstanding_p); a same-cycle pop gives no bypass.
REQ-020 dev_cmd_v_o[i] is asserted exactly one cycle after acceptance, for the target i only, and holds with a stable address and payload until dev_cmd_ready_i[i].
REQ-021 Responses return in command order: only the device at the FIFO head can be consumed; dev_resp_v_i from other devices is ignored and held off.
REQ-022 Response path is combinational: resp_v_o = dev_resp_v_i[head], resp_data_o = its payload, and dev_resp_yumi_o[head] = resp_yumi_i & resp_v_o.
REQ-023 A resp_yumi_i with resp_v_o low is ignored.
REQ-024 When the FIFO is empty: resp_v_o=0 and all dev_resp_yumi_o=0.
REQ-025 Push and pop in the same cycle leave the count unchanged; FIFO pointers wrap modulo outstanding_p.

Reset
REQ-026 While reset_i is high: FIFO empty, output register empty, cmd_ready_o=0, dev_cmd_v_o=0, resp_v_o=0, resp_err_o=0, dev_resp_yumi_o=0.
REQ-027 Reset mid-operation discards all in-flight tags and commands; no response is produced for them afterwards.
REQ-028 cmd_ready_o rises no earlier than the first clock edge after reset_i deasserts.

Configuration
REQ-029 With BP_ADDR_ROUTER_DECODE_ERR_EN defined: an unmapped command is not forwarded, and its tag is marked error.
REQ-030 With the macro defined: at the FIFO head, an error tag gives resp_v_o=1, resp_err_o=1 and resp_data_o=0, and it is popped on resp_yumi_i.
REQ-031 Without the macro: an unmapped command is routed to device 0, and resp_err_o is tied to 0.

Structure
REQ-032 The device count, default base/mask table and the tag typedef {err, dev_id[clog2(num_dev_p)]} shall live in bp_common_pkg.
REQ-033 The order FIFO is one sub-module, bp_addr_router_tag_fifo, with depth outstanding_p and one read and one write port.

Verification
REQ-034 Command to addr 0x8000_1000 -> dev_cmd_v_o=5'b00001 on the next cycle; dev 0 response 0xDEAD -> resp_data_o=0xDEAD, resp_err_o=0.
REQ-035 Commands to 0x0200_4000 then 0x0C00_0000; dev 4 responds before dev 2 -> resp_v_o stays 0 until dev 2 responds; output order is dev 2, then dev 4.
REQ-036 Four commands with no responses -> cmd_ready_o=0; one resp_yumi_i -> cmd_ready_o=1 on the following cycle.
REQ-037 Command to 0x0400_0000 -> with the macro: resp_v_o=1, resp_err_o=1, data 0, no dev_cmd_v_o; without the macro: dev_cmd_v_o=5'b00001.
REQ-038 dev_cmd_ready_i[0] held low for 3 cycles -> dev_cmd_v_o[0], address and payload stay stable, and cmd_ready_o=0 until release.
REQ-039 Assert reset_i with 2 commands outstanding -> all outputs 0 asynchronously; after release, late device responses produce no resp_v_o.
